denumerate: RTL and testbench

- Inverse of the permutation enumerator: takes a permutation index (rank) and produces the packed LUT-input permutation with that rank.
- Used wherever a stored or transmitted index must be expanded back into a LUT input mapping, e.g. config load or exhaustive permutation sweeps.
- Iterative: factoradic digit extraction, then selection from the remaining elements, one step per cycle. Valid/ready on both sides.

---
 rtl/enum_pkg.sv | 33 +++
 rtl/perm_pick.sv | 36 +++
 rtl/denumerate.sv | 182 ++++++++++++++++++
 tb/tb_denumerate.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enum_pkg.sv
// Shared definitions for the permutation enumerator / denumerator pair.
//
// Rank convention: a permutation is the sequence p[0..N-1] of {0..N-1},
// packed with p[i] at prm[i*L +: L]. Its rank is the lexicographic rank over
// all N! permutations with p[0] the most significant position, so rank 0 is
// the identity and rank N!-1 is the reversed sequence. Both the enumerator
// and the denumerator use this convention, so they are exact inverses.
package enum_pkg;

  // Default number of LUT inputs being permuted (supported range 2..8).
  localparam int ENUM_N = 4;

  // Constant-foldable factorial, used for index widths and range checks.
  function automatic int factorial(input int n);
    int f;
    f = 1;
    for (int i = 2; i <= n; i++) begin
      f = f * i;
    end
    return f;
  endfunction

  localparam int ENUM_L  = $clog2(ENUM_N);
  localparam int ENUM_EW = $clog2(factorial(ENUM_N));

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIGIT = 2'd1,
    ST_PICK  = 2'd2,
    ST_DONE  = 2'd3
  } dn_state_e;

endpackage

// File: rtl/perm_pick.sv
// Selects the digit-th (0-based) element of {0..N-1} whose bit is still
// clear in the used mask. Purely combinational.
module perm_pick
  import enum_pkg::*;
#(
  parameter int N = ENUM_N,
  parameter int L = $clog2(N)
) (
  input  logic [N-1:0] used,
  input  logic [L-1:0] digit,
  output logic [L-1:0] elem
);

  logic [L:0] cnt;
  logic       found;

  // Walk the mask from element 0 upwards, counting free slots until the
  // requested one is reached.
  always_comb begin
    // NOTE: every variable gets a default before any branch so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    elem  = '0;
    cnt   = '0;
    found = 1'b0;
    for (int b = 0; b < N; b++) begin
      if (!used[b] && !found) begin
        if (cnt == {1'b0, digit}) begin
          elem  = L'(b);
          found = 1'b1;
        end
        cnt = cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/denumerate.sv
// Expands a permutation rank back into the packed permutation.
// Phase 1 (DIGIT) extracts factoradic digits by repeated division by
// k = 2..N; phase 2 (PICK) turns each digit into an element by choosing the
// digit-th unused value. Valid/ready handshakes on input and output.
module denumerate
  import enum_pkg::*;
#(
  parameter int N  = ENUM_N,
  parameter int L  = $clog2(N),
  parameter int EW = $clog2(factorial(N))
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [EW-1:0]  enm,
  input  logic           in_vld,
  output logic           in_rdy,
  output logic [N*L-1:0] prm,
  output logic           err,
  output logic           out_vld,
  input  logic           out_rdy
);

  localparam int FACT_N = factorial(N);
  // k counts up to N inclusive, so it needs one bit more than an element.
  localparam int KW = L + 1;
  // Working width for the divide step; wide enough to hold divisors up to 8
  // even when EW is tiny.
  localparam int DW = EW + 4;

  dn_state_e              state_q, state_d;
  logic [EW-1:0]          rem_q, rem_d;
  logic [KW-1:0]          k_q, k_d;
  logic [L-1:0]           i_q, i_d;
  logic [N-1:0]           used_q, used_d;
  logic [N-1:0][L-1:0]    digits_q, digits_d;
  logic [N-1:0][L-1:0]    prm_q, prm_d;
  logic                   err_q, err_d;
  logic                   out_vld_q, out_vld_d;
  logic                   in_rdy_q, in_rdy_d;

  logic [DW-1:0]          rem_ext;
  logic [EW-1:0]          div_quot;
  logic [L-1:0]           div_rem;
  logic [L-1:0]           pick_elem;
  logic                   out_of_range;

  assign out_of_range = (32'(enm) >= FACT_N);

  // Divide the running remainder by the current k; k is a small variable,
  // so select among divisions by each constant 2..N.
  always_comb begin
    rem_ext  = DW'(rem_q);
    div_quot = rem_q;
    div_rem  = '0;
    for (int c = 2; c <= N; c++) begin
      if (int'(k_q) == c) begin
        div_quot = EW'(rem_ext / DW'(c));
        div_rem  = L'(rem_ext % DW'(c));
      end
    end
  end

  perm_pick #(
    .N (N),
    .L (L)
  ) u_pick (
    .used  (used_q),
    .digit (digits_q[i_q]),
    .elem  (pick_elem)
  );

  // Next-state and next-output logic for the IDLE/DIGIT/PICK/DONE sequence.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    k_d       = k_q;
    i_d       = i_q;
    used_d    = used_q;
    digits_d  = digits_q;
    prm_d     = prm_q;
    err_d     = err_q;
    out_vld_d = out_vld_q;
    in_rdy_d  = in_rdy_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_vld) begin
          rem_d    = enm;
          in_rdy_d = 1'b0;
          if (out_of_range) begin
            // out_vld rises one cycle later, from DONE.
            err_d   = 1'b1;
            prm_d   = '0;
            state_d = ST_DONE;
          end else begin
            used_d   = '0;
            digits_d = '0;
            k_d      = KW'(2);
            state_d  = ST_DIGIT;
          end
        end
      end

      ST_DIGIT: begin
        // Digit for divisor k lands at position N-k; d[N-1] stays 0.
        for (int j = 0; j < N; j++) begin
          if (j == N - int'(k_q)) begin
            digits_d[j] = div_rem;
          end
        end
        rem_d = div_quot;
        k_d   = k_q + 1'b1;
        if (k_q == KW'(N)) begin
          i_d     = '0;
          state_d = ST_PICK;
        end
      end

      ST_PICK: begin
        prm_d[i_q]        = pick_elem;
        used_d[pick_elem] = 1'b1;
        i_d               = i_q + 1'b1;
        if (i_q == L'(N - 1)) begin
          out_vld_d = 1'b1;
          state_d   = ST_DONE;
        end
      end

      ST_DONE: begin
        if (!out_vld_q) begin
          out_vld_d = 1'b1;
        end else if (out_rdy) begin
          out_vld_d = 1'b0;
          err_d     = 1'b0;
          in_rdy_d  = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      k_q       <= '0;
      i_q       <= '0;
      used_q    <= '0;
      // NOTE: the digit register file is reset as well: it is only N*L bits
      // of flops, and a defined reset image keeps prm/err reproducible.
      digits_q  <= '0;
      prm_q     <= '0;
      err_q     <= 1'b0;
      out_vld_q <= 1'b0;
      in_rdy_q  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments here, so every flop samples the
      // pre-edge value of every other flop regardless of statement order.
      state_q   <= state_d;
      rem_q     <= rem_d;
      k_q       <= k_d;
      i_q       <= i_d;
      used_q    <= used_d;
      digits_q  <= digits_d;
      prm_q     <= prm_d;
      err_q     <= err_d;
      out_vld_q <= out_vld_d;
      in_rdy_q  <= in_rdy_d;
    end
  end

  assign prm     = prm_q;
  assign err     = err_q;
  assign out_vld = out_vld_q;
  assign in_rdy  = in_rdy_q;

endmodule

// File: tb/tb_denumerate.sv
// Self-checking bench for denumerate: directed and exhaustive N=4 runs via a
// scoreboard, plus exhaustive round-trip sweeps on N=3 and N=2 instances.
module tb_denumerate;

  logic clk;
  logic rst;

  // N=4 instance
  logic [4:0] enm;
  logic       in_vld, in_rdy, err, out_vld, out_rdy;
  logic [7:0] prm;

  // N=3 instance
  logic [2:0] enm3;
  logic       in_vld3, in_rdy3, err3, out_vld3, out_rdy3;
  logic [5:0] prm3;

  // N=2 instance
  logic [0:0] enm2;
  logic       in_vld2, in_rdy2, err2, out_vld2, out_rdy2;
  logic [1:0] prm2;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] prm;
    logic       err;
  } exp_t;

  exp_t sb_q[$];

  denumerate #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .enm(enm), .in_vld(in_vld), .in_rdy(in_rdy),
    .prm(prm), .err(err), .out_vld(out_vld), .out_rdy(out_rdy)
  );

  denumerate #(.N(3)) dut3 (
    .clk(clk), .rst(rst), .enm(enm3), .in_vld(in_vld3), .in_rdy(in_rdy3),
    .prm(prm3), .err(err3), .out_vld(out_vld3), .out_rdy(out_rdy3)
  );

  denumerate #(.N(2)) dut2 (
    .clk(clk), .rst(rst), .enm(enm2), .in_vld(in_vld2), .in_rdy(in_rdy2),
    .prm(prm2), .err(err2), .out_vld(out_vld2), .out_rdy(out_rdy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int fact(input int n);
    int f;
    f = 1;
    for (int i = 2; i <= n; i++) f = f * i;
    return f;
  endfunction

  // Reference denumerator: most-significant factoradic digit first.
  function automatic logic [31:0] model_perm(input int r, input int n, input int l);
    bit          used[8];
    logic [31:0] p;
    int          rr, f, d, cnt, sel;
    p  = '0;
    rr = r;
    for (int i = 0; i < 8; i++) used[i] = 1'b0;
    for (int i = 0; i < n; i++) begin
      f   = fact(n - 1 - i);
      d   = rr / f;
      rr  = rr % f;
      cnt = 0;
      sel = 0;
      for (int b = n - 1; b >= 0; b--) begin
        if (!used[b]) cnt++;
      end
      cnt = 0;
      for (int b = 0; b < n; b++) begin
        if (!used[b]) begin
          if (cnt == d) sel = b;
          cnt++;
        end
      end
      used[sel] = 1'b1;
      p = p | (32'(sel) << (i * l));
    end
    return p;
  endfunction

  // Reference enumerator; returns -1 if the value is not a permutation.
  function automatic int rank_of(input logic [31:0] p, input int n, input int l);
    bit used[8];
    int rk, e, sm;
    rk = 0;
    for (int i = 0; i < 8; i++) used[i] = 1'b0;
    for (int i = 0; i < n; i++) begin
      e = int'((p >> (i * l)) & ((32'd1 << l) - 1));
      if (e >= n || used[e]) return -1;
      sm = 0;
      for (int b = 0; b < e; b++) if (!used[b]) sm++;
      rk = rk + sm * fact(n - 1 - i);
      used[e] = 1'b1;
    end
    return rk;
  endfunction

  function automatic exp_t exp_ok(input int r);
    exp_t x;
    x.prm = 8'(model_perm(r, 4, 2));
    x.err = 1'b0;
    return x;
  endfunction

  // Offer one index to the N=4 instance; returns at the negedge after acceptance.
  task automatic put(input int e, input exp_t x);
    int n;
    n = 0;
    while (!in_rdy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("put_rdy", 32'(in_rdy), 1);
    enm    = 5'(e);
    in_vld = 1'b1;
    sb_q.push_back(x);
    @(negedge clk);
    in_vld = 1'b0;
  endtask

  // Wait for the result, compare with the scoreboard, optionally hold
  // backpressure and optionally present the next index during the release.
  task automatic get(input int lat_exp, input int hold, input int nxt, input exp_t nx,
                     output logic [7:0] got_prm);
    int         lat;
    exp_t       x;
    logic [7:0] held;
    lat = 0;
    check("busy_rdy", 32'(in_rdy), 0);
    while (!out_vld && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, lat_exp);
    check("sb_size", sb_q.size(), 1);
    x = '0;
    if (sb_q.size() != 0) x = sb_q.pop_front();
    check("prm", 32'(prm), 32'(x.prm));
    check("err", 32'(err), 32'(x.err));
    got_prm = prm;
    held = prm;
    repeat (hold) begin
      @(negedge clk);
      check("bp_vld", 32'(out_vld), 1);
      check("bp_prm", 32'(prm), 32'(held));
      check("bp_rdy", 32'(in_rdy), 0);
    end
    out_rdy = 1'b1;
    if (nxt >= 0) begin
      enm    = 5'(nxt);
      in_vld = 1'b1;
      sb_q.push_back(nx);
    end
    @(negedge clk);
    out_rdy = 1'b0;
    check("rel_vld", 32'(out_vld), 0);
    check("rel_rdy", 32'(in_rdy), 1);
    check("rel_err", 32'(err), 0);
    if (nxt >= 0) begin
      @(negedge clk);
      in_vld = 1'b0;
      check("b2b_acc", 32'(in_rdy), 0);
    end
  endtask

  task automatic sweep3();
    bit seen[64];
    int lat;
    for (int i = 0; i < 64; i++) seen[i] = 1'b0;
    for (int r = 0; r < 6; r++) begin
      check("rt3_rdy", 32'(in_rdy3), 1);
      enm3    = 3'(r);
      in_vld3 = 1'b1;
      @(negedge clk);
      in_vld3 = 1'b0;
      lat = 0;
      while (!out_vld3 && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      check("rt3_lat", lat, 5);
      check("rt3_err", 32'(err3), 0);
      check("rt3_rank", rank_of(32'(prm3), 3, 2), r);
      check("rt3_uniq", 32'(seen[prm3]), 0);
      seen[prm3] = 1'b1;
      out_rdy3 = 1'b1;
      @(negedge clk);
      out_rdy3 = 1'b0;
    end
  endtask

  task automatic sweep2();
    bit seen[4];
    int lat;
    for (int i = 0; i < 4; i++) seen[i] = 1'b0;
    for (int r = 0; r < 2; r++) begin
      check("rt2_rdy", 32'(in_rdy2), 1);
      enm2    = 1'(r);
      in_vld2 = 1'b1;
      @(negedge clk);
      in_vld2 = 1'b0;
      lat = 0;
      while (!out_vld2 && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      check("rt2_lat", lat, 3);
      check("rt2_err", 32'(err2), 0);
      check("rt2_rank", rank_of(32'(prm2), 2, 1), r);
      check("rt2_uniq", 32'(seen[prm2]), 0);
      seen[prm2] = 1'b1;
      out_rdy2 = 1'b1;
      @(negedge clk);
      out_rdy2 = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] p4;
    bit         seen4[256];
    exp_t       none;
    exp_t       e_err;

    none  = '0;
    e_err = '{prm: 8'h00, err: 1'b1};
    for (int i = 0; i < 256; i++) seen4[i] = 1'b0;

    rst = 1'b1;
    enm = '0;  in_vld = 1'b0;  out_rdy = 1'b0;
    enm3 = '0; in_vld3 = 1'b0; out_rdy3 = 1'b0;
    enm2 = '0; in_vld2 = 1'b0; out_rdy2 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rdy", 32'(in_rdy), 1);
    check("rst_vld", 32'(out_vld), 0);
    check("rst_prm", 32'(prm), 0);
    check("rst_err", 32'(err), 0);
    rst = 1'b0;

    // Directed ranks with hand-derived permutations.
    put(0,  '{prm: 8'hE4, err: 1'b0}); get(7, 0, -1, none, p4);
    put(23, '{prm: 8'h1B, err: 1'b0}); get(7, 0, -1, none, p4);
    put(1,  '{prm: 8'hB4, err: 1'b0}); get(7, 0, -1, none, p4);
    put(9,  '{prm: 8'h39, err: 1'b0}); get(7, 0, -1, none, p4);

    // Out-of-range indices, then an in-range one clears err.
    put(24, e_err); get(1, 0, -1, none, p4);
    put(31, e_err); get(1, 0, -1, none, p4);
    put(5, exp_ok(5)); get(7, 0, -1, none, p4);

    // Backpressure for 5 cycles, then back-to-back accept on release.
    put(10, exp_ok(10)); get(7, 5, 17, exp_ok(17), p4);
    get(7, 0, -1, none, p4);

    // Reset while in PICK discards the in-flight index.
    put(14, exp_ok(14));
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_vld", 32'(out_vld), 0);
    check("mid_rst_rdy", 32'(in_rdy), 1);
    check("mid_rst_prm", 32'(prm), 0);
    sb_q.delete();
    put(7, exp_ok(7)); get(7, 0, -1, none, p4);

    // Exhaustive N=4 round trip.
    for (int r = 0; r < 24; r++) begin
      put(r, exp_ok(r));
      get(7, 0, -1, none, p4);
      check("rt4_rank", rank_of(32'(p4), 4, 2), r);
      check("rt4_uniq", 32'(seen4[p4]), 0);
      seen4[p4] = 1'b1;
    end

    sweep3();
    sweep2();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
